// File: rtl/mac_sched_if.sv
// mac_sched_if: request/result bundle for the shared byte-slice MAC scheduler.
//
// Handshake rule (applies to every channel in this bundle): a transfer happens
// on the rising clock edge where valid and ready are both high. The producer
// holds valid and its payload stable until that edge. Ready may be driven
// combinationally and may depend on valid. Valid never depends on ready.
//
// Signals:
//   req0_*  requester 0: valid/ready, attribute word, coefficient word
//   req1_*  requester 1: same as requester 0
//   res_*   result: valid/ready, 20-bit data, tag naming the owning requester
//   busy    scheduler is not idle
//
// Modports:
//   slave   the scheduler side
//   master  the requester/consumer side
interface mac_sched_if #(
  parameter int ATTR_WIDTH      = 24,
  parameter int RAM1_DATA_WIDTH = 34,
  parameter int ACC_WIDTH       = 20
);
  logic                       req0_valid;
  logic                       req0_ready;
  logic [ATTR_WIDTH-1:0]      req0_attr;
  logic [RAM1_DATA_WIDTH-1:0] req0_coeff;

  logic                       req1_valid;
  logic                       req1_ready;
  logic [ATTR_WIDTH-1:0]      req1_attr;
  logic [RAM1_DATA_WIDTH-1:0] req1_coeff;

  logic                       res_valid;
  logic                       res_ready;
  logic [ACC_WIDTH-1:0]       res_data;
  logic                       res_tag;

  logic                       busy;

  modport slave (
    input  req0_valid, req0_attr, req0_coeff,
    input  req1_valid, req1_attr, req1_coeff,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_data, res_tag,
    output busy
  );

  modport master (
    output req0_valid, req0_attr, req0_coeff,
    output req1_valid, req1_attr, req1_coeff,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_data, res_tag,
    input  busy
  );
endinterface

// File: rtl/mac_sched.sv
// mac_sched: round-robin scheduler and sequencer for one shared byte-slice
// multiply-accumulate datapath.
//
// Two requesters each offer an attribute word (three 8-bit slices) and a
// coefficient word (three 8-bit slices plus a 10-bit bias). One request is
// accepted at a time; the result is
//   sum_k a_k * b_k + bias,  k = 0..2, slices taken MSB first,
// returned with a tag naming the requester.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset; aborts any operation in flight
//   bus  mac_sched_if.slave: req0_*, req1_*, res_*, busy
//
// Sequence per request (T = accept edge):
//   T        latch operands, clear acc, enter MAC
//   T+1..T+3 one slice product accumulated per edge
//   T+4      bias added, res_valid rises
//   DONE     result held until res_ready; the next accept is one cycle later
module mac_sched #(
  parameter int ATTR_WIDTH      = 24,
  parameter int RAM1_DATA_WIDTH = 34,
  parameter int ACC_WIDTH       = 20
) (
  input logic          clk,
  input logic          rst,
  mac_sched_if.slave   bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MAC  = 2'd1;
  localparam logic [1:0] BIAS = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [1:0] LAST_STEP = 2'd2;

  logic [1:0]                 state;
  logic [1:0]                 step;
  logic [ACC_WIDTH-1:0]       acc;
  logic                       last_grant;
  logic [ATTR_WIDTH-1:0]      attr_q;
  logic [RAM1_DATA_WIDTH-1:0] coeff_q;
  logic                       tag_q;

  logic                       res_valid_q;
  logic [ACC_WIDTH-1:0]       res_data_q;
  logic                       res_tag_q;

  logic                       idle;
  logic                       grant0;
  logic                       grant1;
  logic                       accept0;
  logic                       accept1;

  logic [7:0]                 a_sel;
  logic [7:0]                 b_sel;
  logic [15:0]                prod;
  logic [ACC_WIDTH-1:0]       prod_ext;
  logic [ACC_WIDTH-1:0]       bias_ext;

  // --------------------------------------------------------------------------
  // Arbitration. A lone requester always wins; on a tie the requester that
  // did not win last time goes first. last_grant resets to 1 so requester 0
  // takes the first tie. Ready is only offered in IDLE, so at most one ready
  // is ever high.
  // --------------------------------------------------------------------------
  assign idle = (state == IDLE);

  always_comb begin
    grant0 = bus.req0_valid & (~bus.req1_valid | last_grant);
    grant1 = bus.req1_valid & (~bus.req0_valid | ~last_grant);
  end

  assign accept0 = idle & grant0;
  assign accept1 = idle & grant1;

  assign bus.req0_ready = accept0;
  assign bus.req1_ready = accept1;
  assign bus.busy       = ~idle;

  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_tag    = res_tag_q;

  // --------------------------------------------------------------------------
  // Slice selection: step 0 uses the most significant byte of each word.
  // The coefficient slices sit above the 10-bit bias field.
  // --------------------------------------------------------------------------
  always_comb begin
    a_sel = 8'd0;
    b_sel = 8'd0;
    case (step)
      2'd0: begin
        a_sel = attr_q[23:16];
        b_sel = coeff_q[33:26];
      end
      2'd1: begin
        a_sel = attr_q[15:8];
        b_sel = coeff_q[25:18];
      end
      default: begin
        a_sel = attr_q[7:0];
        b_sel = coeff_q[17:10];
      end
    endcase
  end

  // 8x8 unsigned product, carried at 16 bits before zero-extension.
  assign prod     = {8'd0, a_sel} * {8'd0, b_sel};
  assign prod_ext = {{(ACC_WIDTH-16){1'b0}}, prod};
  assign bias_ext = {{(ACC_WIDTH-10){1'b0}}, coeff_q[9:0]};

  // --------------------------------------------------------------------------
  // Sequencer. Worst case is 3*255*255 + 1023 = 196098, below 2^18, so the
  // 20-bit accumulator never wraps.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      step        <= 2'd0;
      acc         <= '0;
      last_grant  <= 1'b1;
      attr_q      <= '0;
      coeff_q     <= '0;
      tag_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_tag_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept0 || accept1) begin
            // Requester inputs are sampled here only; later changes on the
            // request ports have no effect on this operation.
            attr_q     <= accept1 ? bus.req1_attr  : bus.req0_attr;
            coeff_q    <= accept1 ? bus.req1_coeff : bus.req0_coeff;
            tag_q      <= accept1;
            last_grant <= accept1;
            acc        <= '0;
            step       <= 2'd0;
            state      <= MAC;
          end
        end

        MAC: begin
          acc <= acc + prod_ext;
          if (step == LAST_STEP) begin
            step  <= 2'd0;
            state <= BIAS;
          end else begin
            step <= step + 2'd1;
          end
        end

        BIAS: begin
          res_data_q  <= acc + bias_ext;
          res_tag_q   <= tag_q;
          res_valid_q <= 1'b1;
          state       <= DONE;
        end

        DONE: begin
          // res_valid is always high here, so res_ready alone completes the
          // transfer. A new request waits for IDLE on the next cycle.
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_sched.sv
// tb_mac_sched: randomized scoreboard bench for mac_sched.
//
// Accepted requests are scored with a reference model written from the
// arithmetic definition (slice products plus bias). A monitor on the falling
// edge pops the expected queue on every result transfer and also checks
// arbitration order, result latency, hold-while-stalled and result spacing.
module tb_mac_sched;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mac_sched_if #(.ATTR_WIDTH(24), .RAM1_DATA_WIDTH(34), .ACC_WIDTH(20)) bus ();

  mac_sched #(.ATTR_WIDTH(24), .RAM1_DATA_WIDTH(34), .ACC_WIDTH(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [20:0] exp_q[$];   // {tag, data}
  bit          model_last = 1'b1;
  int          acc_cyc    = 0;
  bit          spacing_en = 1'b0;
  int          last_hs    = -1;

  bit          prev_valid = 1'b0;
  bit          prev_ready = 1'b0;
  logic [19:0] prev_data  = '0;
  logic        prev_tag   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  function automatic void fail_now(string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endfunction

  // Reference: sum of the three byte products (MSB slices first) plus bias.
  function automatic logic [19:0] model(logic [23:0] a, logic [33:0] c);
    int unsigned s;
    int unsigned x;
    int unsigned y;
    s = 0;
    for (int k = 0; k < 3; k++) begin
      x = 32'((a >> (16 - 8 * k)) & 24'hFF);
      y = 32'((c >> (26 - 8 * k)) & 34'hFF);
      s += x * y;
    end
    s += 32'(c & 34'h3FF);
    return s[19:0];
  endfunction

  // Monitor: scores accepts and result transfers on the falling edge.
  always @(negedge clk) begin
    logic [20:0] e;
    bit          g;
    if (rst) begin
      exp_q.delete();
      model_last = 1'b1;
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      check("ready_onehot", 64'(bus.req0_ready & bus.req1_ready), 64'd0);
      if (bus.busy && (bus.req0_valid || bus.req1_valid))
        check("no_ready_when_busy", 64'(bus.req0_ready | bus.req1_ready), 64'd0);

      if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready)) begin
        g = bus.req1_valid && bus.req1_ready;
        if (bus.req0_valid && bus.req1_valid)
          check("rr_grant", 64'(g), 64'(!model_last));
        model_last = g;
        exp_q.push_back(g ? {1'b1, model(bus.req1_attr, bus.req1_coeff)}
                          : {1'b0, model(bus.req0_attr, bus.req0_coeff)});
        acc_cyc = cyc;
      end

      if (prev_valid && !prev_ready) begin
        check("hold_valid", 64'(bus.res_valid), 64'd1);
        check("hold_data", 64'(bus.res_data), 64'(prev_data));
        check("hold_tag", 64'(bus.res_tag), 64'(prev_tag));
      end

      if (bus.res_valid && !prev_valid)
        check("latency", 64'(cyc - acc_cyc), 64'd5);

      if (bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_result");
        end else begin
          e = exp_q.pop_front();
          check("res_data", 64'(bus.res_data), 64'(e[19:0]));
          check("res_tag", 64'(bus.res_tag), 64'(e[20]));
        end
        if (spacing_en && last_hs >= 0)
          check("result_spacing", 64'(cyc - last_hs), 64'd6);
        last_hs = cyc;
      end

      prev_valid = bus.res_valid;
      prev_ready = bus.res_ready;
      prev_data  = bus.res_data;
      prev_tag   = bus.res_tag;
    end
  end

  // ------------------------------------------------------------------ drivers
  task automatic set_req(input int id, input logic v, input logic [23:0] a, input logic [33:0] c);
    if (id == 0) begin
      bus.req0_valid = v;
      bus.req0_attr  = a;
      bus.req0_coeff = c;
    end else begin
      bus.req1_valid = v;
      bus.req1_attr  = a;
      bus.req1_coeff = c;
    end
  endtask

  function automatic logic [33:0] rand_coeff();
    return {2'($urandom_range(0, 3)), 32'($urandom)};
  endfunction

  // Issues n requests on one requester. Valid is held until accepted; the
  // payload is scrambled right after the accept edge.
  task automatic drive_req(input int id, input int n, input int max_gap,
                           input bit use_fixed, input logic [23:0] fa, input logic [33:0] fc);
    logic [23:0] a;
    logic [33:0] c;
    bit          got;
    int          gap;
    for (int i = 0; i < n; i++) begin
      a = use_fixed ? fa : 24'($urandom);
      c = use_fixed ? fc : rand_coeff();
      set_req(id, 1'b1, a, c);
      got = 1'b0;
      for (int t = 0; t < 300 && !got; t++) begin
        @(negedge clk);
        if (id == 0) got = bus.req0_valid && bus.req0_ready && !rst;
        else         got = bus.req1_valid && bus.req1_ready && !rst;
      end
      if (!got) begin
        fail_now($sformatf("accept_timeout_req%0d", id));
        set_req(id, 1'b0, 24'd0, 34'd0);
        return;
      end
      @(posedge clk);
      #1;
      set_req(id, 1'b0, 24'($urandom), rand_coeff());
      gap = $urandom_range(0, max_gap);
      repeat (gap) @(posedge clk);
      if (gap > 0) #1;
    end
  endtask

  task automatic wait_done();
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.res_valid) return;
    end
    fail_now("drain_timeout");
  endtask

  task automatic wait_res_valid();
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus.res_valid) return;
    end
    fail_now("res_valid_timeout");
  endtask

  // ----------------------------------------------------------------- watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "simulation time limit");
  end

  // -------------------------------------------------------------------- main
  initial begin
    bit rr_stop;
    bit got;
    rst = 1'b1;
    bus.res_ready = 1'b0;
    set_req(0, 1'b0, 24'd0, 34'd0);
    set_req(1, 1'b0, 24'd0, 34'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset_res_valid", 64'(bus.res_valid), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_res_data", 64'(bus.res_data), 64'd0);
    check("reset_res_tag", 64'(bus.res_tag), 64'd0);
    @(posedge clk);
    #1;

    // Single request on requester 0, then the all-ones case on requester 1.
    bus.res_ready = 1'b1;
    drive_req(0, 1, 0, 1'b1, 24'h010203, 34'h0_1014_180A);
    wait_done();
    drive_req(1, 1, 0, 1'b1, 24'hFFFFFF, 34'h3_FFFF_FFFF);
    wait_done();

    // Both requesters held valid: strict alternation, results 6 cycles apart.
    @(posedge clk);
    #1;
    spacing_en = 1'b1;
    last_hs    = -1;
    fork
      drive_req(0, 4, 0, 1'b0, 24'd0, 34'd0);
      drive_req(1, 4, 0, 1'b0, 24'd0, 34'd0);
    join
    wait_done();
    spacing_en = 1'b0;

    // Backpressure: result stalls 10 cycles while requester 1 waits.
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    drive_req(0, 1, 0, 1'b0, 24'd0, 34'd0);
    wait_res_valid();
    @(posedge clk);
    #1;
    set_req(1, 1'b1, 24'($urandom), rand_coeff());
    repeat (10) begin
      @(negedge clk);
      check("stall_busy", 64'(bus.busy), 64'd1);
      check("stall_req1_ready", 64'(bus.req1_ready), 64'd0);
    end
    @(posedge clk);
    #1 bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("post_done_idle", 64'(bus.busy), 64'd0);
    check("post_done_accept", 64'(bus.req1_ready), 64'd1);
    @(posedge clk);
    #1 set_req(1, 1'b0, 24'($urandom), rand_coeff());
    wait_done();

    // Reset mid-MAC aborts; the next request carries no residue.
    @(posedge clk);
    #1 set_req(0, 1'b1, 24'($urandom), rand_coeff());
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      got = bus.req0_valid && bus.req0_ready;
    end
    if (!got) fail_now("abort_accept_timeout");
    @(posedge clk);
    #1 set_req(0, 1'b0, 24'd0, 34'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    set_req(0, 1'b1, 24'($urandom), rand_coeff());
    @(negedge clk);
    check("abort_res_valid", 64'(bus.res_valid), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_ready", 64'(bus.req0_ready), 64'd1);
    @(posedge clk);
    #1 set_req(0, 1'b0, 24'($urandom), rand_coeff());
    wait_done();

    // Random traffic with random gaps and random result backpressure.
    rr_stop = 1'b0;
    fork
      begin
        fork
          drive_req(0, 12, 3, 1'b0, 24'd0, 34'd0);
          drive_req(1, 12, 3, 1'b0, 24'd0, 34'd0);
        join
        rr_stop = 1'b1;
      end
      begin
        while (!rr_stop) begin
          @(posedge clk);
          #1 bus.res_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.res_ready = 1'b1;
    wait_done();

    if (exp_q.size() != 0) fail_now("results_missing");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
